// File: rtl/rvfi_ser_pkg.sv
// Shared types and constants for the RVFI serializer.
// cva6_cfg_t / cva6_cfg_empty are a minimal local stand-in for the core config.
package rvfi_ser_pkg;

    localparam int DROP_CNT_W = 32;
    localparam int SEQ_W      = 64;

    typedef struct packed {
        int unsigned NrCommitPorts;
    } cva6_cfg_t;

    localparam cva6_cfg_t cva6_cfg_empty = '{NrCommitPorts: 32'd2};

    // Default record layout; any packed struct with valid and trap fields works.
    typedef struct packed {
        logic        valid;
        logic        trap;
        logic [31:0] pc;
        logic [31:0] insn;
    } rvfi_rec_t;

    function automatic int ptr_w(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/rvfi_ser_fifo.sv
// Ring buffer with NW compacted write lanes (first wr_cnt used) and one read port.
// Popped slots are cleared so rd_data reads '0 whenever the buffer is empty.
module rvfi_ser_fifo
    import rvfi_ser_pkg::*;
#(
    parameter int  DEPTH = 8,
    parameter int  NW    = 2,
    parameter int  NCW   = 2,
    parameter type T     = logic,
    localparam int PW    = ptr_w(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic           clk,
    input  logic           rst,
    input  T               wr_data [NW],
    input  logic [NCW-1:0] wr_cnt,
    input  logic           rd_en,
    output T               rd_data,
    output logic [CW-1:0]  count
);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Clear first so a same-cycle write into the freed slot wins.
            if (rd_en) mem[rd_ptr] <= '0;
            for (int j = 0; j < NW; j++) begin
                if (NCW'(j) < wr_cnt) mem[wr_ptr + PW'(j)] <= wr_data[j];
            end
            wr_ptr <= wr_ptr + PW'(wr_cnt);
            rd_ptr <= rd_ptr + PW'(rd_en);
            count  <= count + CW'(wr_cnt) - CW'(rd_en);
        end
    end

endmodule

// File: rtl/rvfi_serializer.sv
// Compacts multi-port RVFI commits into one valid/ready stream; overflow drops, never stalls.
// Optional RVFI_SERIALIZER_SEQ_EN adds a 64-bit per-record sequence tag on seq_o.
module rvfi_serializer
    import rvfi_ser_pkg::*;
#(
    parameter cva6_cfg_t CVA6Cfg      = cva6_cfg_empty,
    parameter type       rvfi_instr_t = rvfi_rec_t,
    parameter int        DEPTH        = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  rvfi_instr_t           rvfi_i [CVA6Cfg.NrCommitPorts],
    output rvfi_instr_t           rvfi_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [ptr_w(DEPTH):0] count_o,
    output logic                  overflow_o,
    output logic [DROP_CNT_W-1:0] drop_cnt_o
`ifdef RVFI_SERIALIZER_SEQ_EN
    ,
    output logic [SEQ_W-1:0]      seq_o
`endif
);

    localparam int NP  = CVA6Cfg.NrCommitPorts;
    localparam int NCW = $clog2(NP + 1);

`ifdef RVFI_SERIALIZER_SEQ_EN
    typedef struct packed {
        logic [SEQ_W-1:0] seq;
        rvfi_instr_t      rec;
    } entry_t;
    logic [SEQ_W-1:0] seq_cnt;
`else
    typedef rvfi_instr_t entry_t;
`endif

    entry_t               wr_data [NP];
    entry_t               rd_data;
    logic [NCW-1:0]       wr_cnt;
    logic                 pop;
    logic [DROP_CNT_W:0]  drop_sum;
    int                   nq;
    int                   nfree;
    int                   npush;
    int                   ndrop;

    assign valid_o = (count_o != '0);
    assign pop     = valid_o & ready_i;

    // Rank each qualifying port in order; ranks past the free space are dropped.
    always_comb begin
        nq    = 0;
        nfree = DEPTH - int'(count_o) + int'(pop);
        for (int j = 0; j < NP; j++) wr_data[j] = '0;
        for (int i = 0; i < NP; i++) begin
            if (rvfi_i[i].valid || rvfi_i[i].trap) begin
                for (int j = 0; j < NP; j++) begin
                    if (j == nq && nq < nfree) begin
`ifdef RVFI_SERIALIZER_SEQ_EN
                        wr_data[j] = '{seq: seq_cnt + SEQ_W'(nq), rec: rvfi_i[i]};
`else
                        wr_data[j] = rvfi_i[i];
`endif
                    end
                end
                nq = nq + 1;
            end
        end
        npush = (nq < nfree) ? nq : nfree;
        ndrop = nq - npush;
    end

    assign wr_cnt   = NCW'(npush);
    assign drop_sum = {1'b0, drop_cnt_o} + (DROP_CNT_W + 1)'(ndrop);

    rvfi_ser_fifo #(
        .DEPTH (DEPTH),
        .NW    (NP),
        .NCW   (NCW),
        .T     (entry_t)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (rst_i),
        .wr_data (wr_data),
        .wr_cnt  (wr_cnt),
        .rd_en   (pop),
        .rd_data (rd_data),
        .count   (count_o)
    );

`ifdef RVFI_SERIALIZER_SEQ_EN
    assign rvfi_o = rd_data.rec;
    assign seq_o  = rd_data.seq;
`else
    assign rvfi_o = rd_data;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            overflow_o <= 1'b0;
            drop_cnt_o <= '0;
        end else if (ndrop != 0) begin
            overflow_o <= 1'b1;
            drop_cnt_o <= drop_sum[DROP_CNT_W] ? '1 : drop_sum[DROP_CNT_W-1:0];
        end
    end

`ifdef RVFI_SERIALIZER_SEQ_EN
    // Dropped records still consume a number so the consumer sees the gap.
    always_ff @(posedge clk_i) begin
        if (rst_i) seq_cnt <= '0;
        else       seq_cnt <= seq_cnt + SEQ_W'(nq);
    end
`endif

endmodule

// File: tb/tb_rvfi_serializer.sv
// Bench for rvfi_serializer (2 ports, depth 4): directed table, then random vs. queue model.
module tb_rvfi_serializer;
    import rvfi_ser_pkg::*;

    localparam int NP    = 2;
    localparam int DEPTH = 4;
    localparam cva6_cfg_t CFG = '{NrCommitPorts: 32'd2};

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ready = 1'b0;
    rvfi_rec_t   rin [NP];
    rvfi_rec_t   rout;
    logic        vld;
    logic [2:0]  cnt;
    logic        ovf;
    logic [31:0] dcnt;
`ifdef RVFI_SERIALIZER_SEQ_EN
    logic [63:0] seq;
`endif

    int nvec = 0;
    int nbad = 0;

    rvfi_serializer #(
        .CVA6Cfg      (CFG),
        .rvfi_instr_t (rvfi_rec_t),
        .DEPTH        (DEPTH)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rvfi_i     (rin),
        .rvfi_o     (rout),
        .valid_o    (vld),
        .ready_i    (ready),
        .count_o    (cnt),
        .overflow_o (ovf),
        .drop_cnt_o (dcnt)
`ifdef RVFI_SERIALIZER_SEQ_EN
        ,
        .seq_o      (seq)
`endif
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue with pop-before-push and drop-on-full.
    rvfi_rec_t          mq [$];
    logic [63:0]        mseq [$];
    bit                 movf;
    longint unsigned    mdrop;
    longint unsigned    mseqcnt;

    task automatic model_step();
        if (rst) begin
            mq.delete(); mseq.delete();
            movf = 0; mdrop = 0; mseqcnt = 0;
        end else begin
            if (mq.size() != 0 && ready) begin
                void'(mq.pop_front());
                void'(mseq.pop_front());
            end
            for (int i = 0; i < NP; i++) begin
                if (rin[i].valid || rin[i].trap) begin
                    if (mq.size() < DEPTH) begin
                        mq.push_back(rin[i]);
                        mseq.push_back(mseqcnt);
                    end else begin
                        movf = 1;
                        if (mdrop < 64'hFFFF_FFFF) mdrop++;
                    end
                    mseqcnt++;
                end
            end
        end
    endtask

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        nvec++;
        if (act !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_step();
        #1;
    endtask

    typedef struct {
        bit          rst, rdy;
        bit          v0, t0;
        logic [31:0] pc0;
        bit          v1, t1;
        logic [31:0] pc1;
        int          cnt;
        logic [31:0] opc;
        bit          ovf;
        int          drop;
        longint      seq;
    } vec_t;

    vec_t tv [$];

    task automatic add(input bit r, input bit rd, input bit v0, input bit t0, input logic [31:0] p0,
                       input bit v1, input bit t1, input logic [31:0] p1,
                       input int c, input logic [31:0] o, input bit ov, input int d, input longint s);
        tv.push_back('{r, rd, v0, t0, p0, v1, t1, p1, c, o, ov, d, s});
    endtask

    task automatic idle(input bit rd, input int c, input logic [31:0] o, input bit ov, input int d,
                        input longint s);
        add(0, rd, 0, 0, 0, 0, 0, 0, c, o, ov, d, s);
    endtask

    initial begin
        rin[0] = '0;
        rin[1] = '0;

        // reset, idle
        add(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1, 0, 0, 0, 0, 0);
        idle(1, 0, 0, 0, 0, 0);
        // dual commit with trap-only port, then port1-only (port0 carries junk pc)
        add(0, 1, 1, 0, 'h100, 0, 1, 'h104, 2, 'h100, 0, 0, 0);
        add(0, 1, 0, 0, 'h9ff, 1, 0, 'h108, 2, 'h104, 0, 0, 1);
        idle(1, 1, 'h108, 0, 0, 2);
        idle(1, 0, 0, 0, 0, 0);
        // backpressure stall
        add(0, 0, 1, 0, 'h200, 0, 0, 0, 1, 'h200, 0, 0, 3);
        for (int k = 0; k < 5; k++) idle(0, 1, 'h200, 0, 0, 3);
        idle(1, 0, 0, 0, 0, 0);
        // overflow
        add(0, 0, 1, 0, 'h300, 1, 0, 'h304, 2, 'h300, 0, 0, 4);
        add(0, 0, 1, 0, 'h308, 1, 0, 'h30c, 4, 'h300, 0, 0, 4);
        add(0, 0, 1, 0, 'h310, 1, 0, 'h314, 4, 'h300, 1, 2, 4);
        // full with simultaneous pop
        add(0, 1, 1, 0, 'h318, 0, 0, 0, 4, 'h304, 1, 2, 5);
        add(0, 1, 1, 0, 'h31c, 1, 0, 'h320, 4, 'h308, 1, 3, 6);
        idle(1, 3, 'h30c, 1, 3, 7);
        idle(1, 2, 'h318, 1, 3, 10);
        idle(1, 1, 'h31c, 1, 3, 11);
        idle(1, 0, 0, 1, 3, 0);
        // reset mid-stream, then capture resumes
        add(0, 0, 1, 0, 'h400, 1, 0, 'h404, 2, 'h400, 1, 3, 13);
        add(0, 0, 1, 0, 'h408, 0, 0, 0, 3, 'h400, 1, 3, 13);
        add(1, 0, 1, 0, 'h40c, 1, 0, 'h410, 0, 0, 0, 0, 0);
        add(0, 1, 1, 0, 'h500, 0, 0, 0, 1, 'h500, 0, 0, 0);
        idle(1, 0, 0, 0, 0, 0);
        // one drop leaves a sequence gap of 1
        add(0, 0, 1, 0, 'h600, 1, 0, 'h604, 2, 'h600, 0, 0, 1);
        add(0, 0, 1, 0, 'h608, 0, 1, 'h60c, 4, 'h600, 0, 0, 1);
        add(0, 0, 0, 1, 'h610, 0, 0, 0, 4, 'h600, 1, 1, 1);
        add(0, 1, 0, 0, 'h9ff, 1, 0, 'h614, 4, 'h604, 1, 1, 2);
        idle(1, 3, 'h608, 1, 1, 3);
        idle(1, 2, 'h60c, 1, 1, 4);
        idle(1, 1, 'h614, 1, 1, 6);
        idle(1, 0, 0, 1, 1, 0);

        #2;
        foreach (tv[n]) begin
            rst    = tv[n].rst;
            ready  = tv[n].rdy;
            rin[0] = '{valid: tv[n].v0, trap: tv[n].t0, pc: tv[n].pc0, insn: ~tv[n].pc0};
            rin[1] = '{valid: tv[n].v1, trap: tv[n].t1, pc: tv[n].pc1, insn: ~tv[n].pc1};
            cyc();
            chk($sformatf("row%0d count", n), 128'(cnt), 128'(tv[n].cnt));
            chk($sformatf("row%0d valid", n), 128'(vld), 128'(tv[n].cnt != 0));
            chk($sformatf("row%0d pc", n), 128'(rout.pc), 128'(tv[n].opc));
            chk($sformatf("row%0d overflow", n), 128'(ovf), 128'(tv[n].ovf));
            chk($sformatf("row%0d drop_cnt", n), 128'(dcnt), 128'(tv[n].drop));
`ifdef RVFI_SERIALIZER_SEQ_EN
            chk($sformatf("row%0d seq", n), 128'(seq), 128'(tv[n].seq));
`endif
        end

        // randomized traffic against the model
        rst = 1;
        for (int c = 0; c < 400; c++) begin
            if (c != 0) rst = ($urandom_range(99) == 0);
            ready = ($urandom_range(9) < 7);
            for (int i = 0; i < NP; i++) begin
                int sel;
                sel = $urandom_range(3);
                rin[i].valid = sel[0];
                rin[i].trap  = sel[1];
                rin[i].pc    = $urandom;
                rin[i].insn  = $urandom;
            end
            cyc();
            begin
                rvfi_rec_t erec;
                logic [63:0] eseq;
                erec = (mq.size() != 0) ? mq[0] : '0;
                eseq = (mseq.size() != 0) ? mseq[0] : 64'd0;
                chk("rnd count", 128'(cnt), 128'(mq.size()));
                chk("rnd valid", 128'(vld), 128'(mq.size() != 0));
                chk("rnd record", 128'(rout), 128'(erec));
                chk("rnd overflow", 128'(ovf), 128'(movf));
                chk("rnd drop_cnt", 128'(dcnt), 128'(mdrop));
`ifdef RVFI_SERIALIZER_SEQ_EN
                chk("rnd seq", 128'(seq), 128'(eseq));
`else
                if (eseq > mseqcnt) chk("rnd seq order", 128'(eseq), 128'(mseqcnt));
`endif
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
